// File: rtl/wordreader_if.sv
// rtl/wordreader_if.sv - serial line, word buffer read port and status bundle for wordreader
interface wordreader_if;
  logic       rx;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       char_valid;
  logic [7:0] char_data;
  logic       frame_err;
  logic       word_done;
  logic [5:0] word_len;
  logic       word_ovf;
  logic       busy;

  modport master (
    output rx, rd_addr,
    input  rd_data, char_valid, char_data, frame_err,
    input  word_done, word_len, word_ovf, busy
  );

  modport slave (
    input  rx, rd_addr,
    output rd_data, char_valid, char_data, frame_err,
    output word_done, word_len, word_ovf, busy
  );
endinterface

// File: rtl/wordreader.sv
// rtl/wordreader.sv - 8N1 serial receiver assembling characters into an idle-terminated word buffer
module wordreader #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int IDLE_BITS    = 20,
  parameter int DEPTH        = 40
) (
  input  logic        sysclk,
  input  logic        rst_n,
  wordreader_if.slave bus
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] LIMIT_M1 = TW'(LIMIT - 1);
  localparam logic [5:0]    DEPTH_W  = 6'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [5:0]    wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic          char_valid_q, char_valid_d;
  logic [7:0]    char_data_q, char_data_d;
  logic          frame_err_q, frame_err_d;
  logic          word_done_q, word_done_d;
  logic [5:0]    word_len_q, word_len_d;
  logic          word_ovf_q, word_ovf_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          wr_en;

  logic [7:0] mem [0:DEPTH-1];

  // Receive FSM, idle-gap word timer, buffer pointer and registered read mux
  always_comb begin
    state_d      = state_q;
    rx_meta_d    = bus.rx;
    rx_s_d       = rx_meta_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    wr_ptr_d     = wr_ptr_q;
    ovf_d        = ovf_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    frame_err_d  = 1'b0;
    word_done_d  = 1'b0;
    word_len_d   = word_len_q;
    word_ovf_d   = word_ovf_q;
    wr_en        = 1'b0;
    rd_data_d    = (bus.rd_addr < DEPTH_W) ? mem[bus.rd_addr[AW-1:0]] : 8'h00;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
          idle_d  = '0;
        end else if (wr_ptr_q != 6'd0 || ovf_q) begin
          // A start bit always wins over an expiring timer on the same cycle
          if (idle_q == LIMIT_M1) begin
            word_done_d = 1'b1;
            word_len_d  = wr_ptr_q;
            word_ovf_d  = ovf_q;
            wr_ptr_d    = 6'd0;
            ovf_d       = 1'b0;
            idle_d      = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            char_valid_d = 1'b1;
            char_data_d  = shift_q;
            // wr_ptr saturates at DEPTH; surplus characters only mark the word
            if (wr_ptr_q < DEPTH_W) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + 6'd1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A line stuck low must not look like a stream of start bits
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchroniser resets to the idle-high level
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      idle_q       <= '0;
      wr_ptr_q     <= 6'd0;
      ovf_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      frame_err_q  <= 1'b0;
      word_done_q  <= 1'b0;
      word_len_q   <= 6'd0;
      word_ovf_q   <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      wr_ptr_q     <= wr_ptr_d;
      ovf_q        <= ovf_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      frame_err_q  <= frame_err_d;
      word_done_q  <= word_done_d;
      word_len_q   <= word_len_d;
      word_ovf_q   <= word_ovf_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Word buffer write port; contents deliberately survive reset
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_data  = char_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.word_done  = word_done_q;
  assign bus.word_len   = word_len_q;
  assign bus.word_ovf   = word_ovf_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_wordreader.sv
// tb/tb_wordreader.sv - self-checking scoreboard bench for wordreader
`timescale 1ns/1ps
module tb_wordreader;
  localparam int CPB       = 16;
  localparam int IDLE_BITS = 4;
  localparam int DEPTH     = 8;
  localparam int WORD_GAP  = IDLE_BITS * CPB;
  // 2 synchroniser cycles, 1 start detect, half a start bit, 8 data bits, 1 stop bit
  localparam int CV_LAT    = 2 + 1 + CPB / 2 + 9 * CPB;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  wordreader_if bus();

  wordreader #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS), .DEPTH(DEPTH)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic [7:0] exp_chars[$];
  logic [6:0] exp_words[$];
  logic [7:0] exp_c;
  logic [6:0] exp_w;
  int n_cv = 0, n_fe = 0, n_wd = 0;
  int last_cv_cyc = 0, last_wd_cyc = 0, frame_cyc = 0;
  bit busy_seen = 1'b0;

  // Scoreboard: pop expectations as pulses appear
  always @(negedge sysclk) begin
    if (bus.busy) busy_seen = 1'b1;
    if (bus.char_valid && bus.word_done) begin
      checks++; errors++;
      $display("FAIL pulse_overlap: char_valid and word_done both high at cycle %0d", cyc);
    end
    if (bus.char_valid) begin
      n_cv++;
      last_cv_cyc = cyc;
      checks++;
      if (exp_chars.size() == 0) begin
        errors++;
        $display("FAIL char_unexpected: got char_data=%h, expected no character", bus.char_data);
      end else begin
        exp_c = exp_chars.pop_front();
        if (bus.char_data !== exp_c) begin
          errors++;
          $display("FAIL char_data: got %h, expected %h", bus.char_data, exp_c);
        end
      end
    end
    if (bus.frame_err) n_fe++;
    if (bus.word_done) begin
      n_wd++;
      last_wd_cyc = cyc;
      checks++;
      if (exp_words.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got len=%0d ovf=%0d, expected no word", bus.word_len, bus.word_ovf);
      end else begin
        exp_w = exp_words.pop_front();
        if ({bus.word_ovf, bus.word_len} !== exp_w) begin
          errors++;
          $display("FAIL word_result: got ovf=%0d len=%0d, expected ovf=%0d len=%0d",
                   bus.word_ovf, bus.word_len, exp_w[6], exp_w[5:0]);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge sysclk); #1;
    frame_cyc = cyc;
    bus.rx = 1'b0;
    repeat (CPB - 1) @(posedge sysclk);
    for (int i = 0; i < 8; i++) begin
      @(posedge sysclk); #1 bus.rx = b[i];
      repeat (CPB - 1) @(posedge sysclk);
    end
    @(posedge sysclk); #1 bus.rx = stop;
    repeat (CPB - 1) @(posedge sysclk);
  endtask

  task automatic wait_word(output bit got);
    int n0 = n_wd;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge sysclk);
      if (n_wd != n0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_buf(input logic [5:0] a, output logic [7:0] d);
    @(posedge sysclk); #1 bus.rd_addr = a;
    @(posedge sysclk);
    @(negedge sysclk);
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    bus.rd_addr = 6'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checks += 8;
    if (bus.char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid: got %b, expected 0", bus.char_valid); end
    if (bus.char_data !== 8'h00) begin errors++; $display("FAIL reset_char_data: got %h, expected 00", bus.char_data); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", bus.frame_err); end
    if (bus.word_done !== 1'b0) begin errors++; $display("FAIL reset_word_done: got %b, expected 0", bus.word_done); end
    if (bus.word_len !== 6'd0) begin errors++; $display("FAIL reset_word_len: got %0d, expected 0", bus.word_len); end
    if (bus.word_ovf !== 1'b0) begin errors++; $display("FAIL reset_word_ovf: got %b, expected 0", bus.word_ovf); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h, expected 00", bus.rd_data); end
    @(negedge sysclk) rst_n = 1'b1;
    repeat (5) @(posedge sysclk);
  endtask

  task automatic test_single();
    int cv0 = n_cv;
    bit got;
    logic [7:0] d;
    busy_seen = 1'b0;
    exp_chars.push_back(8'h48);
    exp_words.push_back({1'b0, 6'd1});
    send_frame(8'h48, 1'b1);
    checks += 3;
    if (n_cv - cv0 != 1) begin errors++; $display("FAIL single_count: got %0d char_valid pulses, expected 1", n_cv - cv0); end
    if (last_cv_cyc - frame_cyc != CV_LAT) begin errors++; $display("FAIL single_latency: got %0d cycles, expected %0d", last_cv_cyc - frame_cyc, CV_LAT); end
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL single_busy: got busy_seen=%b, expected 1", busy_seen); end
    wait_word(got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL single_word_timeout: got no word_done, expected one"); end
    if (last_wd_cyc - last_cv_cyc != WORD_GAP) begin errors++; $display("FAIL single_gap: got %0d cycles, expected %0d", last_wd_cyc - last_cv_cyc, WORD_GAP); end
    read_buf(6'd0, d);
    checks++;
    if (d !== 8'h48) begin errors++; $display("FAIL single_read0: got %h, expected 48", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3];
    int cv0 = n_cv;
    int wd0 = n_wd;
    bit got;
    logic [7:0] d;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21;
    for (int i = 0; i < 3; i++) exp_chars.push_back(msg[i]);
    exp_words.push_back({1'b0, 6'd3});
    for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1);
    wait_word(got);
    checks += 3;
    if (!got) begin errors++; $display("FAIL b2b_word_timeout: got no word_done, expected one"); end
    if (n_cv - cv0 != 3) begin errors++; $display("FAIL b2b_count: got %0d char_valid pulses, expected 3", n_cv - cv0); end
    if (n_wd - wd0 != 1) begin errors++; $display("FAIL b2b_words: got %0d word_done pulses, expected 1", n_wd - wd0); end
    for (int i = 0; i < 3; i++) begin
      read_buf(6'(i), d);
      checks++;
      if (d !== msg[i]) begin errors++; $display("FAIL b2b_read%0d: got %h, expected %h", i, d, msg[i]); end
    end
    read_buf(6'd9, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL b2b_read9: got %h, expected 00", d); end
    read_buf(6'(DEPTH), d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL b2b_read_depth: got %h, expected 00", d); end
  endtask

  task automatic test_glitch();
    int cv0 = n_cv;
    int fe0 = n_fe;
    busy_seen = 1'b0;
    @(posedge sysclk); #1 bus.rx = 1'b0;
    repeat (5) @(posedge sysclk);
    #1 bus.rx = 1'b1;
    repeat (40) @(posedge sysclk);
    @(negedge sysclk);
    checks += 4;
    if (n_cv != cv0) begin errors++; $display("FAIL glitch_char: got %0d char_valid pulses, expected 0", n_cv - cv0); end
    if (n_fe != fe0) begin errors++; $display("FAIL glitch_ferr: got %0d frame_err pulses, expected 0", n_fe - fe0); end
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b, expected 1", busy_seen); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_frame_err();
    int cv0 = n_cv;
    int fe0 = n_fe;
    int wd0 = n_wd;
    bit got;
    logic [7:0] d;
    send_frame(8'h41, 1'b0);
    repeat (100) @(posedge sysclk);
    @(negedge sysclk);
    checks += 3;
    if (n_fe - fe0 != 1) begin errors++; $display("FAIL ferr_count: got %0d frame_err pulses, expected 1", n_fe - fe0); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_high: got busy=%b, expected 1", bus.busy); end
    if (n_cv != cv0) begin errors++; $display("FAIL ferr_char: got %0d char_valid pulses, expected 0", n_cv - cv0); end
    @(posedge sysclk); #1 bus.rx = 1'b1;
    repeat (100) @(posedge sysclk);
    @(negedge sysclk);
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_release: got busy=%b, expected 0", bus.busy); end
    if (n_wd != wd0) begin errors++; $display("FAIL ferr_only_word: got %0d word_done pulses, expected 0", n_wd - wd0); end
    if (n_fe - fe0 != 1) begin errors++; $display("FAIL ferr_retrigger: got %0d frame_err pulses, expected 1", n_fe - fe0); end
    exp_chars.push_back(8'h42);
    exp_words.push_back({1'b0, 6'd1});
    send_frame(8'h42, 1'b1);
    wait_word(got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL ferr_word_timeout: got no word_done, expected one"); end
    if (n_cv - cv0 != 1) begin errors++; $display("FAIL ferr_good_char: got %0d char_valid pulses, expected 1", n_cv - cv0); end
    read_buf(6'd0, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL ferr_read0: got %h, expected 42", d); end
  endtask

  task automatic test_overflow();
    int cv0 = n_cv;
    bit got;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) exp_chars.push_back(8'h30 + 8'(i));
    exp_words.push_back({1'b1, 6'd8});
    for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1);
    wait_word(got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL ovf_word_timeout: got no word_done, expected one"); end
    if (n_cv - cv0 != 10) begin errors++; $display("FAIL ovf_count: got %0d char_valid pulses, expected 10", n_cv - cv0); end
    for (int i = 0; i < DEPTH; i++) begin
      read_buf(6'(i), d);
      checks++;
      if (d !== 8'h30 + 8'(i)) begin errors++; $display("FAIL ovf_read%0d: got %h, expected %h", i, d, 8'h30 + 8'(i)); end
    end
    exp_chars.push_back(8'h5a);
    exp_words.push_back({1'b0, 6'd1});
    send_frame(8'h5a, 1'b1);
    wait_word(got);
    checks++;
    if (!got) begin errors++; $display("FAIL ovf_next_timeout: got no word_done, expected one"); end
    read_buf(6'd0, d);
    checks++;
    if (d !== 8'h5a) begin errors++; $display("FAIL ovf_next_read0: got %h, expected 5a", d); end
    read_buf(6'd1, d);
    checks++;
    if (d !== 8'h31) begin errors++; $display("FAIL ovf_stale_read1: got %h, expected 31", d); end
  endtask

  task automatic test_reset_mid_frame();
    int cv0 = n_cv;
    int fe0 = n_fe;
    int wd0 = n_wd;
    bit got;
    logic [7:0] d;
    logic [7:0] b = 8'h55;
    @(posedge sysclk); #1 bus.rx = 1'b0;
    repeat (CPB - 1) @(posedge sysclk);
    for (int i = 0; i < 4; i++) begin
      @(posedge sysclk); #1 bus.rx = b[i];
      repeat (CPB - 1) @(posedge sysclk);
    end
    repeat (CPB / 2) @(posedge sysclk);
    @(negedge sysclk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b, expected 1", bus.busy); end
    #1 rst_n = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge sysclk);
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", bus.busy); end
    if (bus.char_data !== 8'h00) begin errors++; $display("FAIL rst_mid_char_data: got %h, expected 00", bus.char_data); end
    if (bus.word_len !== 6'd0) begin errors++; $display("FAIL rst_mid_word_len: got %0d, expected 0", bus.word_len); end
    rst_n = 1'b1;
    repeat (300) @(posedge sysclk);
    checks++;
    if (n_cv != cv0 || n_fe != fe0 || n_wd != wd0) begin
      errors++;
      $display("FAIL rst_mid_pulses: got cv=%0d fe=%0d wd=%0d, expected 0 0 0", n_cv - cv0, n_fe - fe0, n_wd - wd0);
    end
    exp_chars.push_back(8'h55);
    exp_words.push_back({1'b0, 6'd1});
    send_frame(8'h55, 1'b1);
    wait_word(got);
    checks++;
    if (!got) begin errors++; $display("FAIL rst_mid_word_timeout: got no word_done, expected one"); end
    read_buf(6'd0, d);
    checks += 2;
    if (d !== 8'h55) begin errors++; $display("FAIL rst_mid_read0: got %h, expected 55", d); end
    if (bus.char_data !== 8'h55) begin errors++; $display("FAIL rst_mid_char_hold: got %h, expected 55", bus.char_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_reset_mid_frame();
    repeat (10) @(posedge sysclk);
    checks++;
    if (exp_chars.size() != 0 || exp_words.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d chars and %0d words outstanding, expected 0", exp_chars.size(), exp_words.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wordreader.md
Name: wordreader

Overview:
Receiving end of the serial character link driven by the board's transmitter: 8N1 frames, idle high, LSB first. Deserialises the line into ASCII characters and assembles consecutive characters into a word buffer. A word ends after a configurable idle gap. The finished word is then exposed through a registered read port, e.g. for display or loopback checking against the switch-selected word.

Parameters:
CLKS_PER_BIT, 5208, sysclk cycles per serial bit (50 MHz / 9600 baud); must be >= 8
IDLE_BITS, 20, idle bit-times with no start bit that terminate a word
DEPTH, 40, word buffer entries; 1..63

Ports:
sysclk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to sysclk, idle high
rd_addr  input  6  word buffer read address
rd_data  output  8  buffer[rd_addr], registered, 1-cycle latency
char_valid  output  1  1-cycle pulse, one good character received
char_data  output  8  last good character, holds until the next one
frame_err  output  1  1-cycle pulse, stop bit sampled low
word_done  output  1  1-cycle pulse, word terminated by idle gap
word_len  output  6  character count of the last finished word, valid from word_done, held
word_ovf  output  1  last finished word exceeded DEPTH, latched with word_len
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, wr_ptr 0, synchroniser flops 1. Buffer RAM contents are not reset. Reset mid-frame abandons the frame, and no pulse is emitted.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s=0 -> START, bit counter cleared.
- START: at count CLKS_PER_BIT/2-1, sample rx_s. If it is 1, this is a glitch: return to IDLE with no output. If it is 0, go to DATA with the counter cleared.
- DATA: sample at count CLKS_PER_BIT-1 and shift the bit in LSB first. After the 8th bit -> STOP.
- STOP: sample at count CLKS_PER_BIT-1.
  - rx_s=1: on the next cycle, char_valid=1 and char_data=byte. If wr_ptr<DEPTH, write buffer[wr_ptr] and increment wr_ptr. Otherwise drop the byte and set an internal ovf flag. Then go to IDLE.
  - rx_s=0: frame_err pulse, byte discarded, wr_ptr unchanged, go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Idle timer:
  - Runs only in IDLE while (wr_ptr!=0 or ovf). Cleared on entry to START.
  - At IDLE_BITS*CLKS_PER_BIT cycles: word_done pulse; word_len<=wr_ptr; word_ovf<=ovf; then wr_ptr<=0, ovf<=0, timer cleared.
  - A word consisting only of framing errors never produces word_done.
- Read port: rd_data <= buffer[rd_addr] every cycle. If rd_addr>=DEPTH, rd_data=0.
  - A read and a write to the same address in the same cycle returns the old data.
  - Buffer contents stay valid after word_done until overwritten by the next word.
- Width rules:
  - Bit counter is wide enough for CLKS_PER_BIT-1.
  - Idle timer is wide enough for IDLE_BITS*CLKS_PER_BIT.
  - wr_ptr saturates at DEPTH and never wraps.
- char_valid and word_done never coincide: word_done can only occur in IDLE after the timer expires.

Test Plan:
(Bench uses CLKS_PER_BIT=16, IDLE_BITS=4, DEPTH=8.)
- Single frame 0x48 ('H') -> char_valid exactly once, 1 cycle after the mid-stop sample; char_data=0x48; busy high during the frame. After 64 idle cycles: word_done with word_len=1, word_ovf=0; rd_addr=0 gives rd_data=0x48 one cycle later.
- Back-to-back "Hi!" (0x48, 0x69, 0x21) with no gap, then idle -> three char_valid pulses, one word_done, word_len=3; addresses 0..2 read back 0x48, 0x69, 0x21; rd_addr=9 gives 0.
- rx low for 5 cycles then high -> no char_valid, no frame_err; busy returns to 0 and the FSM is back in IDLE.
- Frame 0x41 with stop bit low, line held low 100 cycles then released, then valid 0x42 -> frame_err once, stays in WAIT_HIGH while low, then char_valid 0x42; word_len=1 and buffer[0]=0x42.
- Ten characters 0x30..0x39, then idle -> ten char_valid pulses; word_len=8, word_ovf=1, buffer holds 0x30..0x37. The next single-character word gives word_len=1, word_ovf=0.
- rst_n asserted during DATA bit 3 of a frame, released, then a clean 0x55 -> no pulses from the aborted frame; 0x55 is received correctly and word_len=1.
